// File: rtl/div_pkg.sv
// Shared types and width constants for the sequential restoring divider.
package div_pkg;

  localparam int unsigned DW_DEF = 8;
  localparam int unsigned VW_DEF = 4;
  localparam int unsigned CNT_W  = $clog2(DW_DEF);

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } state_e;

endpackage

// File: rtl/div8by4_seq_if.sv
// Operand/result handshake bundle for div8by4_seq.
interface div8by4_seq_if
  import div_pkg::*;
#(
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned VW = VW_DEF
);

  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          div_by_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift in the next dividend bit,
// subtract the divisor if it fits.
module div_step #(
  parameter int unsigned VW = 4
) (
  input  logic [VW:0]   r_i,
  input  logic          d_msb_i,
  input  logic [VW-1:0] v_i,
  output logic [VW:0]   r_o,
  output logic          q_bit_o
);

  logic [VW+1:0] t;

  // r_i is always below the divisor, so its MSB is zero and the full-width trial
  // value equals {r_i[VW-1:0], d_msb_i}.
  always_comb begin
    t       = {r_i, d_msb_i};
    q_bit_o = (t >= {2'b00, v_i});
    r_o     = q_bit_o ? (VW+1)'(t - {2'b00, v_i}) : (VW+1)'(t);
  end

endmodule

// File: rtl/div8by4_seq.sv
// Sequential restoring divider: DW-bit dividend by VW-bit divisor, one quotient bit
// per cycle, valid/ready on both sides.
module div8by4_seq
  import div_pkg::*;
#(
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned VW = VW_DEF
) (
  input logic          clk,
  input logic          rst_n,
  div8by4_seq_if.slave bus
);

  localparam int unsigned CntW = $clog2(DW);

  state_e        state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] d_q, d_d;
  logic [VW-1:0] v_q, v_d;
  logic [VW:0]   r_q, r_d;
  logic [DW-1:0] q_q, q_d;
  logic [DW-1:0] quot_q, quot_d;
  logic [VW-1:0] rem_q, rem_d;
  logic          dbz_q, dbz_d;

  logic [VW:0]   step_r;
  logic          step_q;

  div_step #(
    .VW (VW)
  ) u_step (
    .r_i     (r_q),
    .d_msb_i (d_q[DW-1]),
    .v_i     (v_q),
    .r_o     (step_r),
    .q_bit_o (step_q)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    d_d     = d_q;
    v_d     = v_q;
    r_d     = r_q;
    q_d     = q_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          d_d   = bus.dividend;
          v_d   = bus.divisor;
          r_d   = '0;
          q_d   = '0;
          cnt_d = '0;
          if (bus.divisor == '0) begin
            quot_d  = '1;
            rem_d   = bus.dividend[VW-1:0];
            dbz_d   = 1'b1;
            state_d = StDone;
          end else begin
            dbz_d   = 1'b0;
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        d_d   = d_q << 1;
        r_d   = step_r;
        q_d   = {q_q[DW-2:0], step_q};
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(DW - 1)) begin
          quot_d  = q_d;
          rem_d   = step_r[VW-1:0];
          state_d = StDone;
        end
      end
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      d_q     <= '0;
      v_q     <= '0;
      r_q     <= '0;
      q_q     <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      v_q     <= v_d;
      r_q     <= r_d;
      q_q     <= q_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.in_ready    = (state_q == StIdle);
  assign bus.out_valid   = (state_q == StDone);
  assign bus.quotient    = quot_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;

endmodule
